// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator with timed note durations and octave shift.
// Optional time-multiplexed speaker mixer enabled by the NOTE_MIX_EN macro.
module tone_gen_multi #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned TICK_DIV = 10000
) (
  input  logic                      CLK_1M,
  input  logic                      RESET,
  input  logic [4*CHANNELS-1:0]     NOTE,
  input  logic [2*CHANNELS-1:0]     OCT,
  input  logic [DUR_W*CHANNELS-1:0] DUR,
  input  logic [CHANNELS-1:0]       NOTE_VLD,
  input  logic [CHANNELS-1:0]       STOP,
  output logic [CHANNELS-1:0]       BUFF,
  output logic [CHANNELS-1:0]       BUSY,
  output logic [CHANNELS-1:0]       DONE,
  output logic                      MIX
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0]  RestCode = 4'd15;

  typedef enum logic [1:0] {StIdle, StPlay, StRest} state_e;

  function automatic logic [10:0] note_lim(input logic [3:0] code);
    logic [10:0] lim;
    unique case (code)
      4'd0:    lim = 11'd1911;
      4'd1:    lim = 11'd1703;
      4'd2:    lim = 11'd1517;
      4'd3:    lim = 11'd1276;
      4'd4:    lim = 11'd1136;
      4'd5:    lim = 11'd956;
      4'd6:    lim = 11'd851;
      4'd7:    lim = 11'd758;
      4'd8:    lim = 11'd716;
      4'd9:    lim = 11'd638;
      4'd10:   lim = 11'd568;
      4'd11:   lim = 11'd506;
      4'd12:   lim = 11'd478;
      4'd13:   lim = 11'd451;
      4'd14:   lim = 11'd426;
      default: lim = 11'd0;
    endcase
    return lim;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [3:0]        note_q, note_d;
    logic [1:0]        oct_q, oct_d;
    logic [10:0]       phase_q, phase_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              buff_q, buff_d;
    logic              done_q, done_d;
    logic [10:0]       lim;
    logic              wrap;

    assign lim  = note_lim(note_q) >> oct_q;
    assign wrap = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK_1M) begin
      if (RESET) begin
        state_q <= StIdle;
        note_q  <= '0;
        oct_q   <= '0;
        phase_q <= '0;
        presc_q <= '0;
        dur_q   <= '0;
        buff_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        note_q  <= note_d;
        oct_q   <= oct_d;
        phase_q <= phase_d;
        presc_q <= presc_d;
        dur_q   <= dur_d;
        buff_q  <= buff_d;
        done_q  <= done_d;
      end
    end

    // Priority: new command, then STOP, then normal play/expiry.
    always_comb begin
      state_d = state_q;
      note_d  = note_q;
      oct_d   = oct_q;
      phase_d = phase_q;
      presc_d = presc_q;
      dur_d   = dur_q;
      buff_d  = buff_q;
      done_d  = 1'b0;
      if (NOTE_VLD[i]) begin
        note_d  = NOTE[4*i +: 4];
        oct_d   = OCT[2*i +: 2];
        dur_d   = DUR[DUR_W*i +: DUR_W];
        phase_d = '0;
        presc_d = '0;
        buff_d  = 1'b0;
        state_d = (NOTE[4*i +: 4] == RestCode) ? StRest : StPlay;
      end else if (STOP[i]) begin
        state_d = StIdle;
        phase_d = '0;
        presc_d = '0;
        dur_d   = '0;
        buff_d  = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            phase_d = '0;
            presc_d = '0;
            dur_d   = '0;
            buff_d  = 1'b0;
          end
          StPlay, StRest: begin
            if (state_q == StPlay) begin
              if (phase_q == lim) begin
                phase_d = '0;
                buff_d  = ~buff_q;
              end else begin
                phase_d = phase_q + 11'd1;
              end
            end else begin
              buff_d = 1'b0;
            end
            presc_d = wrap ? '0 : presc_q + PW'(1);
            // A zero duration counter means sustain: it never decrements.
            if (wrap && (dur_q != '0)) begin
              if (dur_q == DUR_W'(1)) begin
                state_d = StIdle;
                phase_d = '0;
                presc_d = '0;
                dur_d   = '0;
                buff_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                dur_d = dur_q - DUR_W'(1);
              end
            end
          end
          default: begin
            state_d = StIdle;
            buff_d  = 1'b0;
          end
        endcase
      end
    end

    assign BUFF[i] = buff_q;
    assign BUSY[i] = (state_q != StIdle);
    assign DONE[i] = done_q;
  end

`ifdef NOTE_MIX_EN
  localparam int unsigned SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [SW-1:0] sel_q, sel_d;
  logic          mix_q, mix_d;

  always_comb begin
    sel_d = (sel_q == SW'(CHANNELS - 1)) ? '0 : sel_q + SW'(1);
    mix_d = BUFF[sel_q];
  end

  always_ff @(posedge CLK_1M) begin
    if (RESET) begin
      sel_q <= '0;
      mix_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      mix_q <= mix_d;
    end
  end

  assign MIX = mix_q;
`else
  assign MIX = 1'b0;
`endif

endmodule

// File: tb/tb_tone_gen_multi.sv
// Directed self-checking bench for tone_gen_multi (CHANNELS=2, TICK_DIV=100).
module tb_tone_gen_multi;

  logic        clk;
  logic        rst;
  logic [7:0]  note;
  logic [3:0]  oct;
  logic [15:0] dur;
  logic [1:0]  vld;
  logic [1:0]  stop;
  logic [1:0]  buff;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic        mix;

  int passed = 0;
  int total  = 0;
  int done0  = 0;
  int done1  = 0;

  tone_gen_multi #(
    .CHANNELS(2),
    .DUR_W   (8),
    .TICK_DIV(100)
  ) dut (
    .CLK_1M  (clk),
    .RESET   (rst),
    .NOTE    (note),
    .OCT     (oct),
    .DUR     (dur),
    .NOTE_VLD(vld),
    .STOP    (stop),
    .BUFF    (buff),
    .BUSY    (busy),
    .DONE    (done),
    .MIX     (mix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done[0] === 1'b1) done0 = done0 + 1;
    if (done[1] === 1'b1) done1 = done1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one command across a single rising edge; returns at the following negedge.
  task automatic strobe(input int ch, input logic [3:0] n, input logic [1:0] o,
                        input logic [7:0] d, input logic with_stop);
    note[4*ch +: 4] = n;
    oct[2*ch +: 2]  = o;
    dur[8*ch +: 8]  = d;
    vld[ch]         = 1'b1;
    stop[ch]        = with_stop;
    tick(1);
    vld  = '0;
    stop = '0;
  endtask

  task automatic stop_ch(input int ch);
    stop[ch] = 1'b1;
    tick(1);
    stop = '0;
  endtask

  initial begin
    logic e;
    logic prev;
    logic expm;
    int   k;
    rst  = 1'b1;
    note = '0;
    oct  = '0;
    dur  = '0;
    vld  = '0;
    stop = '0;
    tick(2);
    check("rst_buff", 32'(buff), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mix", 32'(mix), 32'd0);
    rst = 1'b0;
    tick(1);

    // Timed note: L = 478>>2 = 119.
    strobe(0, 4'd12, 2'd2, 8'd3, 1'b0);
    check("t1_busy_rise", 32'(busy[0]), 32'd1);
    check("t1_buff_start", 32'(buff[0]), 32'd0);
    tick(119);
    check("t1_buff_pre_rise", 32'(buff[0]), 32'd0);
    tick(1);
    check("t1_buff_rise", 32'(buff[0]), 32'd1);
    tick(119);
    check("t1_buff_pre_fall", 32'(buff[0]), 32'd1);
    tick(1);
    check("t1_buff_fall", 32'(buff[0]), 32'd0);
    tick(59);
    check("t1_busy_pre_end", 32'(busy[0]), 32'd1);
    check("t1_done_pre_end", 32'(done[0]), 32'd0);
    tick(1);
    check("t1_done_pulse", 32'(done[0]), 32'd1);
    check("t1_busy_fall", 32'(busy[0]), 32'd0);
    tick(1);
    check("t1_done_one_cycle", 32'(done[0]), 32'd0);
    tick(2);
    check("t1_done_count", 32'(done0), 32'd1);

    // Base pitch, sustain: half period 1912.
    strobe(0, 4'd0, 2'd0, 8'd0, 1'b0);
    tick(1911);
    check("t2_pre_first_rise", 32'(buff[0]), 32'd0);
    tick(1);
    check("t2_first_rise", 32'(buff[0]), 32'd1);
    check("t2_busy", 32'(busy[0]), 32'd1);
    e = 1'b1;
    for (int i = 1; i < 20; i++) begin
      tick(1911);
      check("t2_hold", 32'(buff[0]), 32'(e));
      tick(1);
      e = ~e;
      check("t2_toggle", 32'(buff[0]), 32'(e));
    end
    check("t2_no_done", 32'(done0), 32'd1);
    stop_ch(0);
    check("t2_stop_busy", 32'(busy[0]), 32'd0);
    check("t2_stop_buff", 32'(buff[0]), 32'd0);

    // Rest: busy for exactly 200 cycles with silent output.
    strobe(1, 4'd15, 2'd0, 8'd2, 1'b0);
    for (int i = 1; i <= 200; i++) begin
      check("t3_rest_busy", 32'(busy[1]), 32'd1);
      check("t3_rest_buff", 32'(buff[1]), 32'd0);
      tick(1);
    end
    check("t3_rest_end_busy", 32'(busy[1]), 32'd0);
    check("t3_rest_done", 32'(done[1]), 32'd1);
    tick(2);
    check("t3_rest_done_count", 32'(done1), 32'd1);

    // Retrigger during a rest at cycle 150 with note 5 (L=956).
    strobe(1, 4'd15, 2'd0, 8'd2, 1'b0);
    tick(148);
    strobe(1, 4'd5, 2'd0, 8'd0, 1'b0);
    check("t3_retrig_busy", 32'(busy[1]), 32'd1);
    tick(51);
    check("t3_old_expiry_busy", 32'(busy[1]), 32'd1);
    check("t3_old_expiry_done", 32'(done[1]), 32'd0);
    tick(905);
    check("t3_retrig_pre_rise", 32'(buff[1]), 32'd0);
    tick(1);
    check("t3_retrig_rise", 32'(buff[1]), 32'd1);
    check("t3_retrig_no_done", 32'(done1), 32'd1);
    stop_ch(1);
    check("t3_stop_busy", 32'(busy[1]), 32'd0);

    // STOP together with NOTE_VLD: the note wins.
    strobe(0, 4'd12, 2'd2, 8'd0, 1'b1);
    check("t4_vld_beats_stop", 32'(busy[0]), 32'd1);
    tick(119);
    check("t4_pre_rise", 32'(buff[0]), 32'd0);
    tick(1);
    check("t4_rise", 32'(buff[0]), 32'd1);
    stop_ch(0);
    check("t4_stop_busy", 32'(busy[0]), 32'd0);
    check("t4_stop_buff", 32'(buff[0]), 32'd0);

    // STOP in the expiry cycle suppresses DONE.
    strobe(0, 4'd12, 2'd2, 8'd1, 1'b0);
    tick(99);
    check("t4_pre_expiry_busy", 32'(busy[0]), 32'd1);
    stop[0] = 1'b1;
    tick(1);
    stop = '0;
    check("t4_stop_expiry_busy", 32'(busy[0]), 32'd0);
    check("t4_stop_expiry_done", 32'(done[0]), 32'd0);
    tick(2);
    check("t4_stop_expiry_count", 32'(done0), 32'd1);

    // Reset mid-note on ch1 (L = 426>>3 = 53, high from cycle 55 to 108).
    strobe(1, 4'd14, 2'd3, 8'd2, 1'b0);
    tick(59);
    check("t5_playing_buff", 32'(buff[1]), 32'd1);
    check("t5_playing_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_rst_buff", 32'(buff), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_mix", 32'(mix), 32'd0);
    tick(250);
    check("t5_no_done_after_rst", 32'(done1), 32'd1);
    check("t5_still_idle", 32'(busy), 32'd0);
    strobe(0, 4'd12, 2'd2, 8'd1, 1'b0);
    check("t5_new_busy", 32'(busy[0]), 32'd1);
    tick(99);
    check("t5_new_buff_low", 32'(buff[0]), 32'd0);
    check("t5_new_busy_hold", 32'(busy[0]), 32'd1);
    tick(1);
    check("t5_new_done", 32'(done[0]), 32'd1);
    check("t5_new_busy_fall", 32'(busy[0]), 32'd0);
    tick(2);
    check("t5_new_done_count", 32'(done0), 32'd2);

    // Mixer: ch0 plays, ch1 idle; the select is even on every other edge after reset.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    strobe(0, 4'd14, 2'd3, 8'd0, 1'b0);
    k = 1;
    for (int i = 0; i < 300; i++) begin
      prev = buff[0];
      tick(1);
      k++;
`ifdef NOTE_MIX_EN
      expm = ((k - 1) % 2 == 0) ? prev : 1'b0;
`else
      expm = 1'b0;
`endif
      check("t6_mix", 32'(mix), 32'(expm));
    end
    stop_ch(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
